ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED for set-LEDs or 0xFF for reset.
- It is the opposite direction of the existing PS/2 receive path on ps2c/ps2d, and sits beside that receiver in the I/O section of MemoryUnit.
- The pins are driven open-drain. The block only ever pulls a line low, through an output enable.
- The block runs the full request-to-send, bit-shift and device-acknowledge sequence, and reports done or error to the CPU-side register logic.

---
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_host_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: CPU-side command handshake for the PS/2 host transmitter.
// Latency: none; this is a bundle of wires.
// Backpressure: start is only honoured while busy is low.
// Ports: start/din are driven by the register logic (master); busy/done/error come back from the transmitter (slave).
interface ps2_host_tx_if;
  logic       start;  // one-cycle send request
  logic [7:0] din;    // command byte, sampled on an accepted start
  logic       busy;   // transfer in progress
  logic       done;   // one-cycle pulse: device acknowledged
  logic       error;  // one-cycle pulse: timeout or missing ACK

  modport master (
    output start,
    output din,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  din,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: open-drain PS/2 host-to-device command transmitter.
// Latency: start -> done spans the clock inhibit, request-to-send, 11 device clocks and line release.
// Backpressure: start is ignored while busy; the caller waits for done or error before the next byte.
// Ports: clk/reset (sync, active-high); cpu (slave modport: start, din, busy, done, error);
//        ps2c_in/ps2d_in raw pin levels; ps2c_oe/ps2d_oe pull the respective line low when 1.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQ_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  cpu,
  input  logic          ps2c_in,
  input  logic          ps2d_in,
  output logic          ps2c_oe,
  output logic          ps2d_oe
);

  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FLT_W  = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    RELEASE
  } state_t;

  // Input conditioning
  logic             c_sync1_q, c_sync1_d;
  logic             c_sync2_q, c_sync2_d;
  logic             d_sync1_q, d_sync1_d;
  logic             d_sync2_q, d_sync2_d;
  logic             filt_q, filt_d;
  logic [FLT_W-1:0] fcnt_q, fcnt_d;
  logic             fall_q, fall_d;

  // Transfer control
  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [10:0]      shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             ps2c_oe_q, ps2c_oe_d;
  logic             ps2d_oe_q, ps2d_oe_d;

  // Synchronizers and clock glitch filter.
  always_comb begin
    c_sync1_d = ps2c_in;
    c_sync2_d = c_sync1_q;
    d_sync1_d = ps2d_in;
    d_sync2_d = d_sync1_q;
    filt_d    = filt_q;
    fcnt_d    = '0;
    // Any sample agreeing with the current level restarts the run count.
    if (c_sync2_q != filt_q) begin
      if (fcnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_d = c_sync2_q;
      end else begin
        fcnt_d = fcnt_q + FLT_W'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // Transfer sequencer.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tcnt_d    = tcnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    ps2d_oe_d = ps2d_oe_q;

    case (state_q)
      IDLE: begin
        ps2d_oe_d = 1'b0;
        if (cpu.start && !busy_q) begin
          // Frame LSB first: start(0), data, odd parity, stop(1).
          shift_d = {1'b1, ~^cpu.din, cpu.din, 1'b0};
          busy_d  = 1'b1;
          phase_d = '0;
          state_d = INHIBIT;
        end
      end

      INHIBIT: begin
        ps2d_oe_d = 1'b0;
        if (phase_q == PH_W'(INHIBIT_CYCLES - 1)) begin
          phase_d   = '0;
          ps2d_oe_d = ~shift_q[0];  // start bit pulls data low
          state_d   = REQ;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      REQ: begin
        if (phase_q == PH_W'(REQ_CYCLES - 1)) begin
          phase_d  = '0;
          tcnt_d   = '0;
          bitcnt_d = '0;
          // Start bit is already on the line; drop it so fall 1 drives data bit 0.
          shift_d  = {1'b1, shift_q[10:1]};
          state_d  = SEND;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      SEND: begin
        if (fall_q) begin
          ps2d_oe_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[10:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          // The fall that puts the stop bit out hands over to ACK, so the
          // device's 11th clock is the one that carries the acknowledge.
          if (bitcnt_q == 4'd9) begin
            state_d = ACK;
          end
        end
      end

      ACK: begin
        ps2d_oe_d = 1'b0;
        if (fall_q) begin
          if (!d_sync2_q) begin
            state_d = RELEASE;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      RELEASE: begin
        ps2d_oe_d = 1'b0;
        if (filt_q && d_sync2_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        ps2d_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // Device-clocked phases share one budget; expiry overrides any
    // completion decided above in the same cycle.
    if (state_q == SEND || state_q == ACK || state_q == RELEASE) begin
      if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        error_d   = 1'b1;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        ps2d_oe_d = 1'b0;
      end else begin
        tcnt_d = tcnt_q + TO_W'(1);
      end
    end

    // The host only ever holds the clock during inhibit and request.
    ps2c_oe_d = (state_d == INHIBIT) || (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync1_q <= 1'b1;
      c_sync2_q <= 1'b1;
      d_sync1_q <= 1'b1;
      d_sync2_q <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      fall_q    <= 1'b0;
      state_q   <= IDLE;
      phase_q   <= '0;
      tcnt_q    <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
    end else begin
      c_sync1_q <= c_sync1_d;
      c_sync2_q <= c_sync2_d;
      d_sync1_q <= d_sync1_d;
      d_sync2_q <= d_sync2_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      fall_q    <= fall_d;
      state_q   <= state_d;
      phase_q   <= phase_d;
      tcnt_q    <= tcnt_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ps2c_oe_q <= ps2c_oe_d;
      ps2d_oe_q <= ps2d_oe_d;
    end
  end

  assign cpu.busy  = busy_q;
  assign cpu.done  = done_q;
  assign cpu.error = error_q;
  assign ps2c_oe   = ps2c_oe_q;
  assign ps2d_oe   = ps2d_oe_q;

endmodule
